// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, word step, and the
// instruction field positions also used by the control-unit decode macros.
package fetch_pkg;

  localparam int          INST_W     = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH
  } fetch_state_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/inst_skid_buffer.sv
// One-entry {inst, pc} holding register that catches a fetched word when the
// output slot is occupied by a stalled instruction.
module inst_skid_buffer
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [INST_W-1:0] load_inst,
  input  logic [31:0]       load_pc,
  output logic              skid_valid,
  output logic [INST_W-1:0] skid_inst,
  output logic [31:0]       skid_pc
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      skid_valid <= 1'b0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (load) begin
      skid_valid <= 1'b1;
    end else if (unload) begin
      skid_valid <= 1'b0;
    end
  end

  // NOTE: the data registers are reset too, so a stray unload after reset
  // can never expose X into the decode path.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      skid_inst <= '0;
      skid_pc   <= '0;
    end else if (load) begin
      skid_inst <= load_inst;
      skid_pc   <= load_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, runs the imem req/ready handshake, and
// presents one instruction at a time with a one-entry skid for back-pressure.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic [5:0]        opcode,
  output logic [5:0]        func
);

  fetch_state_t      state, state_nxt;
  logic [31:0]       pc, pc_nxt;
  logic [31:0]       pend_pc, pend_pc_nxt;
  logic [31:0]       target;
  logic              consume;
  logic              word_accept;
  logic              to_slot;
  logic              skid_load;
  logic              skid_unload;
  logic              skid_valid;
  logic [INST_W-1:0] skid_inst;
  logic [31:0]       skid_pc;

  assign target  = align_word(redirect_pc);
  assign consume = inst_valid && !stall;
  assign to_slot = (!inst_valid || consume) && !skid_valid;

  // Address depends only on registered state: no path from stall/redirect.
  assign imem_addr = pc;

  // NOTE: every signal driven here is defaulted first, so no latch can form.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_pc_nxt = pend_pc;
    imem_req    = 1'b0;
    word_accept = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (!skid_valid) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (redirect) begin
            pc_nxt = target;
          end else begin
            pc_nxt      = pc + PC_STEP;
            word_accept = 1'b1;
            if (!to_slot) state_nxt = IDLE;
          end
        end else if (redirect) begin
          pend_pc_nxt = target;
          state_nxt   = FLUSH;
        end
      end
      FLUSH: begin
        // The stale request must complete at its original address.
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_nxt    = redirect ? target : pend_pc;
          state_nxt = REQ;
        end else if (redirect) begin
          pend_pc_nxt = target;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      pc      <= align_word(RESET_PC);
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  assign skid_load   = word_accept && !to_slot;
  assign skid_unload = consume && skid_valid;

  inst_skid_buffer u_skid (
    .clk        (clk),
    .rst_b      (rst_b),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (redirect),
    .load_inst  (imem_rdata),
    .load_pc    (pc),
    .skid_valid (skid_valid),
    .skid_inst  (skid_inst),
    .skid_pc    (skid_pc)
  );

  // Redirect beats everything; a skid entry is older than any new word.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
    end else if (consume && skid_valid) begin
      inst_valid <= 1'b1;
      inst       <= skid_inst;
      inst_pc    <= skid_pc;
    end else if (word_accept && to_slot) begin
      inst_valid <= 1'b1;
      inst       <= imem_rdata;
      inst_pc    <= pc;
    end else if (consume) begin
      inst_valid <= 1'b0;
    end
  end

  assign opcode = inst[OPCODE_MSB:OPCODE_LSB];
  assign func   = inst[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed cycle table, wrap-around
// instance, and a randomized run checked against a program-order model.
module tb_instruction_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        imem_req, imem_ready, stall, redirect;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic        inst_valid;
  logic [5:0]  opcode, func;

  logic        w_imem_req, w_imem_ready, w_stall, w_redirect;
  logic [31:0] w_imem_addr, w_imem_rdata, w_redirect_pc, w_inst, w_inst_pc;
  logic        w_inst_valid;
  logic [5:0]  w_opcode, w_func;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Zero-latency combinational memory model for both instances.
  assign imem_rdata   = imem_addr ^ KEY;
  assign w_imem_rdata = w_imem_addr ^ KEY;

  instruction_fetch dut (
    .clk (clk), .rst_b (rst_b),
    .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_ready (imem_ready), .imem_rdata (imem_rdata),
    .stall (stall), .redirect (redirect), .redirect_pc (redirect_pc),
    .inst_valid (inst_valid), .inst (inst), .inst_pc (inst_pc),
    .opcode (opcode), .func (func)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk), .rst_b (rst_b),
    .imem_req (w_imem_req), .imem_addr (w_imem_addr),
    .imem_ready (w_imem_ready), .imem_rdata (w_imem_rdata),
    .stall (w_stall), .redirect (w_redirect), .redirect_pc (w_redirect_pc),
    .inst_valid (w_inst_valid), .inst (w_inst), .inst_pc (w_inst_pc),
    .opcode (w_opcode), .func (w_func)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic r, input logic [31:0] rp,
                     input logic rdy, input logic ereq, input logic [31:0] eaddr,
                     input logic eiv, input logic [31:0] eipc);
    vec_t v;
    v.stall = s; v.redirect = r; v.rpc = rp; v.ready = rdy;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_iv = eiv; v.exp_ipc = eipc;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
    stall = s; redirect = r; redirect_pc = rp; imem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst inst_valid", inst_valid, 0);
    check("rst imem_req", imem_req, 0);
    check("rst inst", inst, 0);
    check("rst inst_pc", inst_pc, 0);
    check("rst opcode", opcode, 0);
    check("rst func", func, 0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst wrap imem_addr", w_imem_addr, 32'hFFFF_FFFC);
    check("rst wrap imem_req", w_imem_req, 0);
    rst_b = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc, hold_addr, stall_pc, ei;
    logic        hold_pending, stall_pending;
    logic        s, r, rdy;
    logic [31:0] rp;
    int          n_consumed;

    w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0; w_imem_ready = 1'b1;

    // stall, redirect, redirect_pc, ready | imem_req, imem_addr, inst_valid, inst_pc
    add(0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0);
    add(0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0);
    add(0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0);
    add(0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4);
    add(1, 0, 32'h0,   1, 1, 32'hC,   1, 32'h8);
    for (int i = 0; i < 4; i++) add(1, 0, 32'h0, 1, 0, 32'h10, 1, 32'h8);
    add(0, 0, 32'h0,   1, 0, 32'h10,  1, 32'h8);
    add(0, 0, 32'h0,   1, 0, 32'h10,  1, 32'hC);
    add(0, 0, 32'h0,   1, 1, 32'h10,  0, 32'h0);
    add(0, 1, 32'h100, 1, 1, 32'h14,  1, 32'h10);
    add(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    add(0, 0, 32'h0,   0, 1, 32'h104, 1, 32'h100);
    add(0, 1, 32'h200, 0, 1, 32'h104, 0, 32'h0);
    add(0, 1, 32'h300, 0, 1, 32'h104, 0, 32'h0);
    add(0, 1, 32'h400, 0, 1, 32'h104, 0, 32'h0);
    add(0, 0, 32'h0,   1, 1, 32'h104, 0, 32'h0);
    add(0, 0, 32'h0,   1, 1, 32'h400, 0, 32'h0);
    add(0, 1, 32'h500, 0, 1, 32'h404, 1, 32'h400);
    add(0, 1, 32'h603, 1, 1, 32'h404, 0, 32'h0);
    add(0, 0, 32'h0,   1, 1, 32'h600, 0, 32'h0);
    add(0, 0, 32'h0,   0, 1, 32'h604, 1, 32'h600);

    do_reset();
    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].redirect, vq[i].rpc, vq[i].ready);
      check($sformatf("v%0d imem_req", i), imem_req, vq[i].exp_req);
      check($sformatf("v%0d imem_addr", i), imem_addr, vq[i].exp_addr);
      check($sformatf("v%0d inst_valid", i), inst_valid, vq[i].exp_iv);
      if (vq[i].exp_iv) begin
        ei = vq[i].exp_ipc ^ KEY;
        check($sformatf("v%0d inst_pc", i), inst_pc, vq[i].exp_ipc);
        check($sformatf("v%0d inst", i), inst, ei);
        check($sformatf("v%0d opcode", i), opcode, ei[31:26]);
        check($sformatf("v%0d func", i), func, ei[5:0]);
      end
      @(negedge clk);
    end

    // Wrap-around: second fetch after 0xFFFF_FFFC is 0x0000_0000.
    do_reset();
    drive(0, 0, 32'h0, 0);
    check("wrap c0 imem_req", w_imem_req, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0);
    check("wrap c1 imem_req", w_imem_req, 1);
    check("wrap c1 imem_addr", w_imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(0, 0, 32'h0, 0);
    check("wrap c2 imem_addr", w_imem_addr, 32'h0);
    check("wrap c2 inst_valid", w_inst_valid, 1);
    check("wrap c2 inst_pc", w_inst_pc, 32'hFFFF_FFFC);
    check("wrap c2 inst", w_inst, 32'hFFFF_FFFC ^ KEY);
    @(negedge clk);

    // Randomized run: consumed instructions must follow program order,
    // restarting at each redirect target (the redirecting one is accepted).
    do_reset();
    exp_pc = 32'h0;
    hold_pending = 1'b0; stall_pending = 1'b0;
    hold_addr = '0; stall_pc = '0;
    n_consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      s   = ($urandom_range(0, 99) < 30);
      r   = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 60);
      rp  = $urandom() & 32'h0000_0FFF;
      drive(s, r, rp, rdy);
      if (imem_req) check("rnd addr aligned", imem_addr & 32'h3, 32'h0);
      if (hold_pending) begin
        check("rnd req held", imem_req, 1);
        check("rnd addr held", imem_addr, hold_addr);
      end
      if (stall_pending) begin
        check("rnd stall inst_valid", inst_valid, 1);
        check("rnd stall inst_pc", inst_pc, stall_pc);
      end
      if (inst_valid && !stall) begin
        check("rnd order inst_pc", inst_pc, exp_pc);
        check("rnd order inst", inst, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      hold_pending  = imem_req && !imem_ready;
      hold_addr     = imem_addr;
      stall_pending = inst_valid && stall && !redirect;
      stall_pc      = inst_pc;
      @(negedge clk);
    end
    check("rnd progress", 32'(n_consumed > 300), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS core: owns the PC, issues word requests to instruction memory over a req/ready handshake, and presents one instruction at a time, plus its `opcode` and `func` slices, to the control unit and decode logic.
- Handles back-pressure from decode through a one-entry skid buffer.
- Handles branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk` in 1, single clock, all state on rising edge.
- `rst_b` in 1, asynchronous active-low reset.
- `imem_req` out 1, request valid; address held stable until `imem_ready`.
- `imem_addr` out 32, word address, bits [1:0] always 0.
- `imem_ready` in 1, memory accepts and returns `imem_rdata` this cycle (combinational response allowed).
- `imem_rdata` in 32, instruction word, valid only when `imem_req && imem_ready`.
- `stall` in 1, decode cannot accept the presented instruction this cycle.
- `redirect` in 1, taken branch/jump/JR; flush and restart at `redirect_pc`.
- `redirect_pc` in 32, target; bits [1:0] forced to 0 internally.
- `inst_valid` out 1, `inst`/`inst_pc` hold a valid instruction.
- `inst` out 32, registered instruction.
- `inst_pc` out 32, address of `inst`.
- `opcode` out 6, `inst[31:26]`, combinational slice to the control unit.
- `func` out 6, `inst[5:0]`, combinational slice to the control unit.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - Output slot: `inst_valid`, `inst`, `inst_pc`.
  - Skid entry: `skid_valid`, `skid_inst`, `skid_pc`.
  - `pend_pc`: saved redirect target.
  - `state`.
- Consume event: `inst_valid && !stall`.
- FSM states:
  - **IDLE**: `imem_req=0`.
    - Go to REQ when `skid_valid==0`.
    - On `redirect`: `pc<=redirect_pc`, then go to REQ.
  - **REQ**: `imem_req=1`, `imem_addr=pc`.
    - On `imem_ready` without redirect: `pc<=pc+4` (mod 2^32) and place the word, see "Word placement" below. Stay in REQ unless the word went to skid, then go to IDLE.
    - On `imem_ready` with redirect: discard the word, `pc<=redirect_pc`, stay in REQ.
    - Redirect without `imem_ready`: `pend_pc<=redirect_pc`, go to FLUSH.
  - **FLUSH**: `imem_req=1`, `imem_addr` = old `pc`, held stable.
    - On `imem_ready`: discard the word, `pc<=pend_pc`, go to REQ.
    - A further redirect overwrites `pend_pc` (latest wins). If it coincides with `imem_ready`, the new target is used directly.
- Word placement:
  - Goes to the output slot if the slot is empty or being consumed this cycle and `skid_valid==0`.
  - Otherwise goes to skid.
  - A REQ is never accepted while skid is full (IDLE guarantees this), so a word is never dropped.
- Output slot update priority, highest first:
  1. `redirect` clears `inst_valid` and `skid_valid`.
  2. On consume with `skid_valid`, skid moves to the output slot.
  3. On consume or empty slot, the new memory word loads the slot.
  4. On consume with nothing new, `inst_valid<=0`.
- While `stall` is high and no redirect occurs, `inst`/`inst_pc` stay stable.
- Redirect in the same cycle as a consume: the consumed instruction is the branch itself and is considered accepted. Everything younger is flushed.

## Timing
- Asynchronous reset values:
  - `state=IDLE`, `pc=RESET_PC`.
  - `inst_valid=0`, `inst=0`, `inst_pc=0`, so `opcode=0` and `func=0`.
  - `skid_valid=0`, `pend_pc=0`, `imem_req=0`.
- Reset mid-request abandons the transaction. Memory must tolerate `imem_req` dropping.
- First `imem_req` is asserted in the first cycle after reset release.
- Latency: `imem_ready` in cycle N puts `inst_valid=1` in cycle N+1.
- Throughput: zero-wait memory and no stall give one instruction per cycle.
- Redirect penalty:
  - Redirect in cycle N with `imem_ready` in the same cycle: `imem_addr=redirect_pc` in N+1.
  - Otherwise: extra cycles until the outstanding request completes.
- `imem_req`/`imem_addr` are a function of `state`/`pc`/`pend_pc` only; no combinational path from `stall` or `redirect`.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {IDLE, REQ, FLUSH}.
  - `INST_W=32`, `PC_STEP=4`.
  - `OPCODE_MSB/LSB` and `FUNC_MSB/LSB` slice constants, shared with the control-unit macros.
- One sub-module, `inst_skid_buffer`:
  - 1-entry {inst, pc} holding register.
  - Load, unload and flush controls.
  - Provides `skid_valid` status.

## Test plan
- **Reset/streaming:** release reset, zero-wait memory returning `addr^32'hA5A5_0000`, `stall=0` → `imem_addr` 0,4,8,…; `inst_pc` 0,4,8,… one per cycle starting the cycle after the first `imem_ready`.
- **Back-pressure:** `stall=1` for 5 cycles while `inst_pc=8` → `inst`/`inst_pc` frozen, at most one word (pc 12) captured in skid, `imem_req=0` afterwards. Release → pc 12 presented next cycle, no loss or duplication.
- **Redirect with ready:** redirect to 32'h0000_0100 in the same cycle as `imem_ready` → `inst_valid=0` next cycle, `imem_addr=0x100` next cycle, discarded word never appears.
- **Redirect during wait:** memory with 3-cycle latency, redirect to 0x200 in the second wait cycle → `imem_addr` held at the old address until ready, word discarded, then `imem_addr=0x200`.
- **Double redirect in FLUSH:** redirect to 0x300 then 0x400 before ready → fetch resumes at 0x400.
- **Wrap and alignment:** `RESET_PC=32'hFFFF_FFFC` → second fetch at 0x0000_0000; redirect_pc 0x0000_0103 → fetch at 0x0000_0100.
